// File: rtl/lcd_reader_if.sv
// Host-side request/response signals plus the LCD pin group for the read controller.
// The slave modport belongs to lcd_reader; the master modport is the host/top-level view.
interface lcd_reader_if;
  logic       start;
  logic       CS;
  logic       RS;
  logic       poll;
  logic [7:0] LCD_D_in;
  logic [7:0] data;
  logic       busy_flag;
  logic [6:0] addr;
  logic       done;
  logic       timeout;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;

  modport slave (
    input  start, CS, RS, poll, LCD_D_in,
    output data, busy_flag, addr, done, timeout, LCD_RS, LCD_RW, LCD_E
  );

  modport master (
    output start, CS, RS, poll, LCD_D_in,
    input  data, busy_flag, addr, done, timeout, LCD_RS, LCD_RW, LCD_E
  );
endinterface

// File: rtl/lcd_reader.sv
// HD44780 read-cycle controller: single BF/AC or data read, or busy-flag polling
// with a bounded number of reads. Shares the LCD bus with the write controller.
module lcd_reader #(
  parameter int          SETUP     = 3,
  parameter int          PW_E      = 12,
  parameter int          HOLD      = 1,
  parameter int          POLL_GAP  = 4,
  parameter logic [15:0] MAX_POLLS = 16'd50000
) (
  input logic         clk,
  input logic         reset_n,
  lcd_reader_if.slave bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PH_MAX = imax(imax(SETUP, PW_E), imax(HOLD, POLL_GAP));
  localparam int CW     = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP - 1);
  localparam logic [CW-1:0] PW_LAST    = CW'(PW_E - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(POLL_GAP - 1);

  // Poll count saturates so a huge MAX_POLLS can never wrap back into "keep polling".
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0]   polls, polls_nx;
  logic          rs_q, rs_nx;
  logic          poll_q, poll_nx;
  logic          timeout_q, timeout_nx;
  logic [7:0]    data_q, data_nx;
  logic          bf_q, bf_nx;
  logic [6:0]    addr_q, addr_nx;
  logic          e_q, rw_q, lrs_q, done_q;
  logic          bus_rd_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      polls     <= '0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= '0;
      bf_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      polls     <= polls_nx;
      rs_q      <= rs_nx;
      poll_q    <= poll_nx;
      timeout_q <= timeout_nx;
      data_q    <= data_nx;
      bf_q      <= bf_nx;
      addr_q    <= addr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    polls_nx   = polls;
    rs_nx      = rs_q;
    poll_nx    = poll_q;
    timeout_nx = timeout_q;
    data_nx    = data_q;
    bf_nx      = bf_q;
    addr_nx    = addr_q;

    case (state)
      S_IDLE: begin
        if (bus.start && bus.CS) begin
          rs_nx      = bus.RS;
          poll_nx    = bus.poll & ~bus.RS;
          timeout_nx = 1'b0;
          polls_nx   = '0;
          cnt_nx     = '0;
          state_nx   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nx   = '0;
          state_nx = S_PULSE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_PULSE: begin
        if (cnt == PW_LAST) begin
          // Sample on the final E-high edge, where the LCD output has long settled.
          data_nx = bus.LCD_D_in;
          if (!rs_q) begin
            bf_nx   = bus.LCD_D_in[7];
            addr_nx = bus.LCD_D_in[6:0];
          end
          polls_nx = sat_inc(polls);
          cnt_nx   = '0;
          state_nx = S_HOLD;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx = '0;
          if (poll_q && data_q[7] && (polls < MAX_POLLS)) begin
            state_nx = S_GAP;
          end else begin
            if (poll_q && data_q[7]) timeout_nx = 1'b1;
            state_nx = S_DONE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = S_SETUP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus_rd_nx = (state_nx == S_SETUP) || (state_nx == S_PULSE) || (state_nx == S_HOLD);

  // Pin outputs are registered from the next state so they are glitch-free,
  // and the async reset still drops E/RW immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q    <= 1'b0;
      rw_q   <= 1'b0;
      lrs_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      e_q    <= (state_nx == S_PULSE);
      rw_q   <= bus_rd_nx;
      lrs_q  <= bus_rd_nx & rs_nx;
      done_q <= (state_nx == S_DONE);
    end
  end

  assign bus.data      = data_q;
  assign bus.busy_flag = bf_q;
  assign bus.addr      = addr_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.LCD_E     = e_q;
  assign bus.LCD_RW    = rw_q;
  assign bus.LCD_RS    = lrs_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: default-parameter instance plus a MAX_POLLS=3 instance.
module tb_lcd_reader;
  logic clk;
  logic reset_n;

  logic       sel;
  logic       start, CS, RS, poll;
  logic [7:0] LCD_D_in;

  lcd_reader_if ba ();
  lcd_reader_if bb ();

  assign ba.start    = start & ~sel;
  assign bb.start    = start & sel;
  assign ba.CS       = CS;
  assign bb.CS       = CS;
  assign ba.RS       = RS;
  assign bb.RS       = RS;
  assign ba.poll     = poll;
  assign bb.poll     = poll;
  assign ba.LCD_D_in = LCD_D_in;
  assign bb.LCD_D_in = LCD_D_in;

  lcd_reader u_a (.clk(clk), .reset_n(reset_n), .bus(ba.slave));
  lcd_reader #(.MAX_POLLS(16'd3)) u_b (.clk(clk), .reset_n(reset_n), .bus(bb.slave));

  logic       m_E, m_RW, m_RS, m_done, m_timeout, m_bf;
  logic [7:0] m_data;
  logic [6:0] m_addr;
  assign m_E       = sel ? bb.LCD_E     : ba.LCD_E;
  assign m_RW      = sel ? bb.LCD_RW    : ba.LCD_RW;
  assign m_RS      = sel ? bb.LCD_RS    : ba.LCD_RS;
  assign m_done    = sel ? bb.done      : ba.done;
  assign m_timeout = sel ? bb.timeout   : ba.timeout;
  assign m_bf      = sel ? bb.busy_flag : ba.busy_flag;
  assign m_data    = sel ? bb.data      : ba.data;
  assign m_addr    = sel ? bb.addr      : ba.addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int         r_rises, r_high, r_done_at, r_done_cnt, r_rw_hi, r_rs_bad, r_stab_bad;
  int         rise_at[8];
  logic       r_tmo0, r_tmo_done, r_bf;
  logic [7:0] r_data;
  logic [6:0] r_addr;

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic start_read(input logic s, input logic rs, input logic pl);
    sel   = s;
    RS    = rs;
    poll  = pl;
    CS    = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic monitor(input int inject_at, input logic exp_rs,
                         input logic [7:0] d_first, input int n_first, input logic [7:0] d_after);
    logic pe, prs, prw;
    pe = 1'b0; prs = 1'b0; prw = 1'b0;
    r_rises = 0; r_high = 0; r_done_at = -1; r_done_cnt = 0;
    r_rw_hi = 0; r_rs_bad = 0; r_stab_bad = 0;
    r_tmo0 = 1'bx; r_tmo_done = 1'bx; r_bf = 1'bx; r_data = 'x; r_addr = 'x;
    for (int i = 0; i < 8; i++) rise_at[i] = -1;
    for (int n = 0; n < 400; n++) begin
      start = (n == inject_at);
      if (m_E && !pe) begin
        if (r_rises < 8) rise_at[r_rises] = n;
        r_rises++;
      end
      LCD_D_in = (r_rises <= n_first) ? d_first : d_after;
      if (m_E) r_high++;
      if (m_E && pe && ((m_RS != prs) || (m_RW != prw))) r_stab_bad++;
      if (m_RW) r_rw_hi++;
      if ((m_RW && (m_RS != exp_rs)) || (!m_RW && m_RS)) r_rs_bad++;
      if (n == 0) r_tmo0 = m_timeout;
      if (m_done) begin
        r_done_cnt++;
        if (r_done_at < 0) begin
          r_done_at  = n;
          r_tmo_done = m_timeout;
          r_bf       = m_bf;
          r_data     = m_data;
          r_addr     = m_addr;
        end
      end
      pe = m_E; prs = m_RS; prw = m_RW;
      if (r_done_at >= 0 && n >= r_done_at + 4) break;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  int act;

  initial begin
    reset_n = 1'b0; sel = 1'b0; start = 1'b0; CS = 1'b0; RS = 1'b0; poll = 1'b0;
    LCD_D_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_E", m_E, 1'b0);
    chk("rst_RW", m_RW, 1'b0);
    chk("rst_done", m_done, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_RS", m_RS, 1'b0);
    chk("idle_data", m_data, 8'h00);
    chk("idle_tmo", m_timeout, 1'b0);

    // start without chip select
    sel = 1'b0; CS = 1'b0; start = 1'b1;
    act = 0;
    for (int n = 0; n < 20; n++) begin
      if (n == 3) start = 1'b0;
      if (m_RW || m_E || m_done) act++;
      @(posedge clk);
      #1;
    end
    chk("cs0_activity", act, 0);

    // single BF/AC read
    LCD_D_in = 8'h25;
    start_read(1'b0, 1'b0, 1'b0);
    monitor(-1, 1'b0, 8'h25, 100, 8'h25);
    chk("bf_rises", r_rises, 1);
    chk("bf_rise_at", rise_at[0], 3);
    chk("bf_e_width", r_high, 12);
    chk("bf_done_at", r_done_at, 16);
    chk("bf_done_cnt", r_done_cnt, 1);
    chk("bf_rw_cycles", r_rw_hi, 16);
    chk("bf_rs", r_rs_bad, 0);
    chk("bf_stable", r_stab_bad, 0);
    chk("bf_busy", r_bf, 1'b0);
    chk("bf_addr", r_addr, 7'h25);
    chk("bf_tmo", r_tmo_done, 1'b0);

    // data read leaves BF/AC alone
    start_read(1'b0, 1'b1, 1'b1);
    monitor(-1, 1'b1, 8'h59, 100, 8'h59);
    chk("dr_rises", r_rises, 1);
    chk("dr_done_at", r_done_at, 16);
    chk("dr_data", r_data, 8'h59);
    chk("dr_rs", r_rs_bad, 0);
    chk("dr_busy", r_bf, 1'b0);
    chk("dr_addr", r_addr, 7'h25);

    // poll until BF clears on the fourth read
    start_read(1'b0, 1'b0, 1'b1);
    monitor(-1, 1'b0, 8'h80, 3, 8'h05);
    chk("pc_rises", r_rises, 4);
    chk("pc_gap1", rise_at[1] - rise_at[0], 20);
    chk("pc_gap2", rise_at[2] - rise_at[1], 20);
    chk("pc_gap3", rise_at[3] - rise_at[2], 20);
    chk("pc_done_at", r_done_at, 76);
    chk("pc_done_cnt", r_done_cnt, 1);
    chk("pc_rw_cycles", r_rw_hi, 64);
    chk("pc_stable", r_stab_bad, 0);
    chk("pc_busy", r_bf, 1'b0);
    chk("pc_addr", r_addr, 7'h05);
    chk("pc_tmo", r_tmo_done, 1'b0);

    // poll timeout on the MAX_POLLS=3 instance
    start_read(1'b1, 1'b0, 1'b1);
    monitor(-1, 1'b0, 8'hFF, 100, 8'hFF);
    chk("to_rises", r_rises, 3);
    chk("to_done_at", r_done_at, 56);
    chk("to_tmo", r_tmo_done, 1'b1);
    chk("to_busy", r_bf, 1'b1);
    chk("to_addr", r_addr, 7'h7F);
    chk("to_held", m_timeout, 1'b1);
    start_read(1'b1, 1'b1, 1'b0);
    monitor(-1, 1'b1, 8'h41, 100, 8'h41);
    chk("to_clear", r_tmo0, 1'b0);
    chk("to_next_data", r_data, 8'h41);

    // start pulsed mid-PULSE is ignored
    start_read(1'b0, 1'b0, 1'b0);
    monitor(8, 1'b0, 8'hA7, 100, 8'hA7);
    chk("mp_rises", r_rises, 1);
    chk("mp_done_at", r_done_at, 16);
    chk("mp_done_cnt", r_done_cnt, 1);
    chk("mp_busy", r_bf, 1'b1);
    chk("mp_addr", r_addr, 7'h27);

    // asynchronous reset in the middle of E high
    LCD_D_in = 8'h33;
    start_read(1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("ar_pre_E", m_E, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_E", m_E, 1'b0);
    chk("ar_RW", m_RW, 1'b0);
    chk("ar_RS", m_RS, 1'b0);
    chk("ar_done", m_done, 1'b0);
    chk("ar_data", m_data, 8'h00);
    chk("ar_busy", m_bf, 1'b0);
    chk("ar_addr", m_addr, 7'h00);
    chk("ar_tmo", m_timeout, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    LCD_D_in = 8'h12;
    start_read(1'b0, 1'b0, 1'b0);
    monitor(-1, 1'b0, 8'h12, 100, 8'h12);
    chk("ar_rise_at", rise_at[0], 3);
    chk("ar_e_width", r_high, 12);
    chk("ar_done_at", r_done_at, 16);
    chk("ar_addr_after", r_addr, 7'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
